// File: rtl/cache_way_ctrl.sv
// cache_way_ctrl
//   Control FSM for an 8-way set-associative L1 cache. It sequences hit
//   completion, dirty-victim write-back and line fill over the physical
//   memory handshake. On a miss it picks the first invalid way, or the
//   pLRU way when the set is full. It also keeps hit/miss counters.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mem_read/write  CPU request, held until mem_resp
//   index           set index of the request (forwarded as plru_index)
//   hit_vec         per-way tag match of the indexed set
//   valid_vec       valid bits of the indexed set
//   dirty_vec       dirty bits of the indexed set
//   plru_way        pLRU victim suggestion for the indexed set
//   pmem_resp       physical memory done pulse
//   mem_resp        CPU request complete pulse
//   pmem_read/write fill / write-back request levels
//   addr_sel        pmem address source (1 = victim tag, 0 = request tag)
//   way_sel         way addressed by the datapath this cycle
//   data_load, data_src, tag_load, valid_set, dirty_set, dirty_clr
//                   datapath array write strobes for way_sel
//   plru_load, plru_access, plru_index
//                   pLRU tree update port
//   hit_count, miss_count
//                   wrapping 16-bit performance counters
module cache_way_ctrl #(
  parameter int s_index = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [s_index-1:0] index,
  input  logic [7:0]         hit_vec,
  input  logic [7:0]         valid_vec,
  input  logic [7:0]         dirty_vec,
  input  logic [2:0]         plru_way,
  input  logic               pmem_resp,
  output logic               mem_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic               addr_sel,
  output logic [2:0]         way_sel,
  output logic               data_load,
  output logic               data_src,
  output logic               tag_load,
  output logic               valid_set,
  output logic               dirty_set,
  output logic               dirty_clr,
  output logic               plru_load,
  output logic [2:0]         plru_access,
  output logic [s_index-1:0] plru_index,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL
  } state_t;

  state_t     state;
  logic [2:0] victim;
  logic [7:0] match;
  logic       hit;
  logic [2:0] hit_way;
  logic [2:0] choose;
  logic       request;

  assign request    = mem_read | mem_write;
  assign plru_index = index;

  // A tag match only counts on a valid way; several matches resolve to
  // the lowest way (descending scan so the lowest index wins).
  always_comb begin
    match   = hit_vec & valid_vec;
    hit     = |match;
    hit_way = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (match[i]) hit_way = 3'(i);
    end
  end

  // Prefer filling an empty way; only a full set consults the pLRU tree.
  always_comb begin
    choose = plru_way;
    for (int i = 7; i >= 0; i--) begin
      if (!valid_vec[i]) choose = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      victim     <= 3'd0;
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (request) state <= COMPARE;
        end
        COMPARE: begin
          if (!request) begin
            state <= IDLE;
          end else if (hit) begin
            hit_count <= hit_count + 16'd1;
            state     <= IDLE;
          end else begin
            victim     <= choose;
            miss_count <= miss_count + 16'd1;
            // Only a valid, dirty victim needs writing back before refill.
            state      <= (valid_vec[choose] & dirty_vec[choose]) ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) state <= FILL;
        end
        FILL: begin
          // Return to COMPARE so the refilled line completes the request.
          if (pmem_resp) state <= COMPARE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    addr_sel    = 1'b0;
    way_sel     = 3'd0;
    data_load   = 1'b0;
    data_src    = 1'b0;
    tag_load    = 1'b0;
    valid_set   = 1'b0;
    dirty_set   = 1'b0;
    dirty_clr   = 1'b0;
    plru_load   = 1'b0;
    plru_access = 3'd0;
    case (state)
      COMPARE: begin
        if (request && hit) begin
          mem_resp    = 1'b1;
          plru_load   = 1'b1;
          plru_access = hit_way;
          way_sel     = hit_way;
          if (mem_write) begin
            data_load = 1'b1;
            dirty_set = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        addr_sel   = 1'b1;
        way_sel    = victim;
        if (pmem_resp) dirty_clr = 1'b1;
      end
      FILL: begin
        pmem_read = 1'b1;
        way_sel   = victim;
        if (pmem_resp) begin
          data_load = 1'b1;
          data_src  = 1'b1;
          tag_load  = 1'b1;
          valid_set = 1'b1;
          dirty_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cache_way_ctrl.md
# cache_way_ctrl

Control FSM for the 8-way set-associative L1 cache. It sequences hit/miss handling, write-back and fill over the physical-memory handshake, and picks the victim way: first invalid way, otherwise the pLRU tree's way. It drives the pLRU tree's update port on every completed access and keeps hit/miss performance counters. It sits between the CPU-side request interface and the cache datapath (tag/data/valid/dirty arrays and the pLRU tree).

## Interface
- s_index, 3, set-index width; passed through to pLRU tree, used only for `plru_index`

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_read  in  1  CPU read request, held until `mem_resp`
- mem_write  in  1  CPU write request, held until `mem_resp`
- index  in  s_index  set index of current request
- hit_vec  in  8  per-way tag match for indexed set (datapath, combinational)
- valid_vec  in  8  valid bits of indexed set
- dirty_vec  in  8  dirty bits of indexed set
- plru_way  in  3  pLRU victim way for indexed set
- pmem_resp  in  1  physical memory done, one-cycle pulse
- mem_resp  out  1  CPU request complete, one-cycle pulse
- pmem_read  out  1  fill request, level, held until `pmem_resp`
- pmem_write  out  1  write-back request, level, held until `pmem_resp`
- addr_sel  out  1  pmem address source: 1 = victim tag (write-back), 0 = request tag
- way_sel  out  3  way addressed by datapath this cycle
- data_load  out  1  write data array at `way_sel`
- data_src  out  1  data array input: 0 = CPU write data, 1 = pmem line
- tag_load  out  1  write request tag into `way_sel`
- valid_set  out  1  set valid bit of `way_sel`
- dirty_set  out  1  set dirty bit of `way_sel`
- dirty_clr  out  1  clear dirty bit of `way_sel`
- plru_load  out  1  pLRU tree update strobe
- plru_access  out  3  way reported to pLRU tree
- plru_index  out  s_index  equals `index`
- hit_count  out  16  completed hits, wraps at 0xFFFF→0
- miss_count  out  16  misses detected, wraps

## Operation
- States: IDLE, COMPARE, WRITEBACK, FILL. State, `victim` (3b) and counters are registered. All other outputs are combinational from state and inputs.
- `hit` = |(hit_vec & valid_vec). `hit_way` = lowest-index set bit of (hit_vec & valid_vec). Multi-hit resolves to the lowest index, not an error.
- `choose` = lowest-index zero bit of `valid_vec` if any way is invalid, else `plru_way`.
- IDLE: all outputs 0. Go to COMPARE when `mem_read | mem_write`.
- COMPARE, no request (dropped): go to IDLE with no side effects.
- COMPARE, hit:
  - Drive `mem_resp`=1, `plru_load`=1, `plru_access`=`way_sel`=`hit_way`.
  - If `mem_write`: also `data_load`=1, `data_src`=0, `dirty_set`=1.
  - `hit_count`+1. Go to IDLE.
- COMPARE, miss:
  - `victim` ← `choose`; `miss_count`+1.
  - If `valid_vec[choose] & dirty_vec[choose]`: go to WRITEBACK. Else go to FILL.
- WRITEBACK: `pmem_write`=1, `addr_sel`=1, `way_sel`=`victim`. On `pmem_resp`: `dirty_clr`=1, go to FILL.
- FILL: `pmem_read`=1, `addr_sel`=0, `way_sel`=`victim`. On `pmem_resp`: `data_load`=1, `data_src`=1, `tag_load`=1, `valid_set`=1, `dirty_clr`=1, go to COMPARE.
  - The re-compare hits and completes the request. The miss is therefore counted once and the hit once.
- WRITEBACK and FILL are not abortable. A CPU request dropped mid-miss still finishes the memory transaction, then COMPARE sees no request and returns to IDLE.
- `pmem_read` and `pmem_write` are never both 1.

## Timing
- Reset: state IDLE, `victim`=0, `hit_count`=`miss_count`=0. Every output is 0 in the cycle after the reset edge.
- Reset mid-WRITEBACK/FILL aborts the transaction: pmem strobes drop after the reset edge.
- Hit latency: request seen in IDLE at cycle 0; `mem_resp` in cycle 1.
- Clean miss: `mem_resp` = 1 (COMPARE) + N (FILL, N = cycles until `pmem_resp` inclusive) + 1 (COMPARE) cycles after IDLE.
- Dirty miss: adds the WRITEBACK duration M.
- `pmem_resp` arriving while in IDLE or COMPARE is ignored.
- After `mem_resp` the FSM sits in IDLE for at least one cycle. Back-to-back requests are spaced 2 cycles apart on hits.
- Counter wrap: 0xFFFF + 1 = 0x0000, no saturation, no flag.

## Test plan
- Read hit: valid_vec=0xFF, hit_vec=0x20, mem_read=1 → cycle 1 `mem_resp`=1, `plru_load`=1, `plru_access`=5, `hit_count`=1, no pmem activity.
- Write hit: hit_vec=0x04, mem_write=1 → `data_load`=1, `data_src`=0, `dirty_set`=1, `way_sel`=2 in the same cycle as `mem_resp`.
- Clean miss with invalid way: valid_vec=0xF7, hit_vec=0 → victim=3, FILL. After `pmem_resp` at cycle 4: `tag_load`/`valid_set`/`data_load`=1 with `way_sel`=3. `mem_resp` follows once datapath hit_vec=0x08. `miss_count`=1.
- Dirty miss, full set: valid_vec=0xFF, dirty_vec=0x40, plru_way=6 → WRITEBACK with `pmem_write`=1, `addr_sel`=1; then `dirty_clr`; then FILL with `pmem_read`=1, `addr_sel`=0; then COMPARE and `mem_resp`.
- Reset during FILL, and request dropped during WRITEBACK:
  - Reset → all outputs 0 next cycle, counters 0.
  - Dropped request → write-back and fill both complete, then IDLE with no `mem_resp`.
- Multi-hit and counter wrap:
  - hit_vec=0x81 → way 0 selected.
  - Preload 65535 hits, then one more → `hit_count`=0.
